// File: rtl/ar_reg.sv
// ar_reg: 16-bit CPU address register (AR) of the MERA-400 datapath.
// The register loads from the W bus while l_ is low. It steps +1 on a p1
// falling edge and -M_STEP on an m4 rising edge. Both strobes are sampled
// and edge-detected in the clk_sys domain. The output ar is taken straight
// from the register, so no input reaches it combinationally.
module ar_reg #(
  parameter int WIDTH  = 16,
  parameter int M_STEP = 4
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [WIDTH-1:0] w,
  input  logic             l_,
  input  logic             p1,
  input  logic             m4,
  output logic [WIDTH-1:0] ar
);

  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DN = WIDTH'(M_STEP);

  logic p1_q;
  logic m4_q;
  logic p1_fall;
  logic m4_rise;

  // Edge detection against the level seen on the previous clk_sys edge.
  // The history registers clear to 0, so m4 high right after reset reads
  // as a rise and p1 high right after reset does not read as a fall.
  always_comb begin
    p1_fall = p1_q & ~p1;
    m4_rise = ~m4_q & m4;
  end

  // Strobe history and AR update. A load consumes any edge that arrives
  // in the same cycle. Coincident edges apply the net +1-M_STEP step.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ar   <= '0;
      p1_q <= 1'b0;
      m4_q <= 1'b0;
    end else begin
      p1_q <= p1;
      m4_q <= m4;
      if (!l_)
        ar <= w;
      else if (p1_fall && m4_rise)
        ar <= ar + STEP_UP - STEP_DN;
      else if (p1_fall)
        ar <= ar + STEP_UP;
      else if (m4_rise)
        ar <= ar - STEP_DN;
    end
  end

endmodule

// File: tb/tb_ar_reg.sv
// tb_ar_reg: directed scoreboard bench for ar_reg. Each step drives the
// inputs on the falling clock edge and queues the expected ar. After the
// next rising edge, the step pops the queued value and checks it against
// the DUT output.
module tb_ar_reg;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] w       = 16'h0000;
  logic        l_      = 1'b1;
  logic        p1      = 1'b0;
  logic        m4      = 1'b0;
  logic [15:0] ar;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  ar_reg #(.WIDTH(16), .M_STEP(4)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .w       (w),
    .l_      (l_),
    .p1      (p1),
    .m4      (m4),
    .ar      (ar)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input logic r, input logic [15:0] wv, input logic lv,
                      input logic pv, input logic mv, input logic [15:0] expv,
                      input string tag);
    logic [15:0] e;
    string       t;
    @(negedge clk_sys);
    rst = r;
    w   = wv;
    l_  = lv;
    p1  = pv;
    m4  = mv;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk_sys);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (ar === e) else begin
      miscompares++;
      $error("FAIL %s: ar=%h expected %h", t, ar, e);
    end
  endtask

  initial begin
    // reset and idle
    step(1, 16'h0000, 1, 0, 0, 16'h0000, "reset");
    step(0, 16'h0000, 1, 0, 0, 16'h0000, "idle_after_reset");

    // load, then hold with w ignored
    step(0, 16'hBEEF, 0, 0, 0, 16'hBEEF, "load_beef");
    for (int i = 0; i < 5; i++)
      step(0, 16'h5555, 1, 0, 0, 16'hBEEF, "hold_beef");

    // increment on p1 falls only
    step(0, 16'h0000, 1, 1, 0, 16'hBEEF, "p1_rise_noop");
    step(0, 16'h0000, 1, 0, 0, 16'hBEF0, "p1_fall_inc");
    step(0, 16'h0000, 1, 0, 0, 16'hBEF0, "p1_held_low");
    step(0, 16'h0000, 1, 1, 0, 16'hBEF0, "p1_rise2_noop");
    step(0, 16'h0000, 1, 0, 0, 16'hBEF1, "p1_fall2_inc");

    // decrement on m4 rise only
    step(0, 16'h0000, 1, 0, 1, 16'hBEED, "m4_rise_dec");
    for (int i = 0; i < 3; i++)
      step(0, 16'h0000, 1, 0, 1, 16'hBEED, "m4_held_high");
    step(0, 16'h0000, 1, 0, 0, 16'hBEED, "m4_fall_noop");

    // wrap-around both ways
    step(0, 16'hFFFF, 0, 0, 0, 16'hFFFF, "load_ffff");
    step(0, 16'h0000, 1, 1, 0, 16'hFFFF, "wrap_p1_rise");
    step(0, 16'h0000, 1, 0, 0, 16'h0000, "wrap_inc");
    step(0, 16'h0002, 0, 0, 0, 16'h0002, "load_0002");
    step(0, 16'h0000, 1, 0, 1, 16'hFFFE, "wrap_dec");
    step(0, 16'h0000, 1, 0, 0, 16'hFFFE, "wrap_m4_fall");

    // load beats a p1 fall; the edge is lost
    step(0, 16'h0000, 1, 1, 0, 16'hFFFE, "prio_p1_arm");
    step(0, 16'h1234, 0, 0, 0, 16'h1234, "prio_load_over_fall");
    step(0, 16'h0000, 1, 0, 0, 16'h1234, "prio_fall_consumed");

    // simultaneous p1 fall and m4 rise: net -3
    step(0, 16'h0010, 0, 1, 0, 16'h0010, "load_0010");
    step(0, 16'h0000, 1, 0, 1, 16'h000D, "both_edges");
    step(0, 16'h0000, 1, 0, 0, 16'h000D, "both_hold");

    // load beats an m4 rise; the edge is lost
    step(0, 16'hABCD, 0, 0, 1, 16'hABCD, "prio_load_over_rise");
    step(0, 16'h0000, 1, 0, 1, 16'hABCD, "prio_rise_consumed");

    // reset mid-value; m4 held through reset gives one decrement
    step(0, 16'hBEEF, 0, 0, 1, 16'hBEEF, "load_beef2");
    step(0, 16'h0000, 1, 0, 0, 16'hBEEF, "m4_release");
    step(1, 16'h0000, 1, 0, 1, 16'h0000, "reset_mid");
    step(0, 16'h0000, 1, 0, 1, 16'hFFFC, "m4_after_reset");
    step(0, 16'h0000, 1, 0, 1, 16'hFFFC, "m4_after_reset_hold");

    // p1 high across reset is not a fall; its later fall is
    step(0, 16'h0000, 1, 0, 0, 16'hFFFC, "m4_release2");
    step(1, 16'h0000, 1, 1, 0, 16'h0000, "reset_p1_high");
    step(0, 16'h0000, 1, 1, 0, 16'h0000, "p1_high_after_reset");
    step(0, 16'h0000, 1, 0, 0, 16'h0001, "p1_fall_after_reset");

    // reset discards a pending p1 fall
    step(0, 16'h0000, 1, 1, 0, 16'h0001, "p1_arm_before_reset");
    step(1, 16'h0000, 1, 0, 0, 16'h0000, "reset_eats_fall");
    step(0, 16'h0000, 1, 0, 0, 16'h0000, "no_fall_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
